// File: rtl/trng_byte_arbiter.sv
// rtl/trng_byte_arbiter.sv - round-robin TRNG byte sharing with repetition and timeout health checks
//
// Shares the TRNG bit collector among N_REQ requesters. One requester at a time
// is granted and served its requested number of bytes over a valid/ready stream
// tagged with its id. A repetition-count test and a collection timeout lock the
// block in FAIL until clear_fail.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req, req_len      per-requester request level and byte count (slice i = [i*LEN_W +: LEN_W])
//   grant             one-hot currently served requester
//   collector_enable  enable for the bit collector
//   byte_ready        one-cycle pulse from the collector, rand_byte valid with it
//   out_valid/out_data/out_id/out_last/out_ready  delivered byte stream
//   busy              any state other than IDLE
//   health_fail       sticky failure flag, fail_code 01 = repetition, 10 = timeout
//   clear_fail        leaves FAIL
module trng_byte_arbiter #(
  parameter int N_REQ       = 4,
  parameter int LEN_W       = 8,
  parameter int REP_LIMIT   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*LEN_W-1:0]     req_len,
  output logic [N_REQ-1:0]           grant,
  output logic                       collector_enable,
  input  logic                       byte_ready,
  input  logic [7:0]                 rand_byte,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  output logic [$clog2(N_REQ)-1:0]   out_id,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       health_fail,
  output logic [1:0]                 fail_code,
  input  logic                       clear_fail
);

  localparam int IDW   = $clog2(N_REQ);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DELIVER = 2'd2,
    S_FAIL    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     win_q, win_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [7:0]         data_q, data_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [REP_W-1:0]   rep_q, rep_d, rep_next;
  logic [7:0]         prev_q, prev_d;
  logic               prev_vld_q, prev_vld_d;
  logic [1:0]         code_q, code_d;

  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               cen_q, cen_d;
  logic               ov_q, ov_d;
  logic [7:0]         od_q, od_d;
  logic [IDW-1:0]     oid_q, oid_d;
  logic               olast_q, olast_d;
  logic               busy_q, busy_d;
  logic               hf_q, hf_d;

  logic [N_REQ-1:0]   elig;
  logic               arb_found;
  logic [IDW-1:0]     arb_pick;

  // A zero-length request is never eligible, so it can never be granted.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req[i] && (req_len[i*LEN_W +: LEN_W] != '0);
    end
  end

  // First eligible index at or after the pointer, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!arb_found && elig[(int'(ptr_q) + k) % N_REQ]) begin
        arb_found = 1'b1;
        arb_pick  = IDW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  // State register plus all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      ptr_q      <= '0;
      rem_q      <= '0;
      data_q     <= '0;
      tmo_q      <= '0;
      rep_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      code_q     <= 2'b00;
      grant_q    <= '0;
      cen_q      <= 1'b0;
      ov_q       <= 1'b0;
      od_q       <= '0;
      oid_q      <= '0;
      olast_q    <= 1'b0;
      busy_q     <= 1'b0;
      hf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      tmo_q      <= tmo_d;
      rep_q      <= rep_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      code_q     <= code_d;
      grant_q    <= grant_d;
      cen_q      <= cen_d;
      ov_q       <= ov_d;
      od_q       <= od_d;
      oid_q      <= oid_d;
      olast_q    <= olast_d;
      busy_q     <= busy_d;
      hf_q       <= hf_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    rep_d      = rep_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    code_d     = code_q;
    rep_next   = (prev_vld_q && (rand_byte == prev_q)) ? rep_q + REP_W'(1) : REP_W'(1);

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          state_d = S_COLLECT;
          win_d   = arb_pick;
          ptr_d   = (arb_pick == IDW'(N_REQ - 1)) ? '0 : arb_pick + IDW'(1);
          rem_d   = req_len[int'(arb_pick)*LEN_W +: LEN_W];
          tmo_d   = '0;
        end
      end
      S_COLLECT: begin
        // Abort has priority over a byte arriving in the same cycle.
        if (!req[win_q]) begin
          state_d = S_IDLE;
        end else if (byte_ready) begin
          prev_d     = rand_byte;
          prev_vld_d = 1'b1;
          rep_d      = rep_next;
          if (rep_next >= REP_W'(REP_LIMIT)) begin
            state_d = S_FAIL;
            code_d  = 2'b01;
          end else begin
            data_d  = rand_byte;
            state_d = S_DELIVER;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_FAIL;
          code_d  = 2'b10;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DELIVER: begin
        if (!req[win_q]) begin
          state_d = S_IDLE;
        end else if (ov_q && out_ready) begin
          rem_d = rem_q - LEN_W'(1);
          if (olast_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_COLLECT;
            tmo_d   = '0;
          end
        end
      end
      S_FAIL: begin
        if (clear_fail) begin
          state_d    = S_IDLE;
          code_d     = 2'b00;
          rep_d      = '0;
          prev_vld_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the next state so that
  // every output comes straight from a flop.
  always_comb begin
    grant_d = '0;
    if (state_d == S_COLLECT || state_d == S_DELIVER) begin
      grant_d[win_d] = 1'b1;
    end
    cen_d   = (state_d == S_COLLECT);
    ov_d    = (state_d == S_DELIVER);
    od_d    = ov_d ? data_d : 8'h00;
    oid_d   = ov_d ? win_d : '0;
    olast_d = ov_d && (rem_d == LEN_W'(1));
    busy_d  = (state_d != S_IDLE);
    hf_d    = (state_d == S_FAIL);
  end

  assign grant            = grant_q;
  assign collector_enable = cen_q;
  assign out_valid        = ov_q;
  assign out_data         = od_q;
  assign out_id           = oid_q;
  assign out_last         = olast_q;
  assign busy             = busy_q;
  assign health_fail      = hf_q;
  assign fail_code        = code_q;

endmodule

// File: doc/trng_byte_arbiter.md
Name: trng_byte_arbiter

Overview:
- Sequences the TRNG bit collector and shares its byte stream among N_REQ requesters.
- Each requester asks for a fixed number of bytes. A round-robin arbiter grants one requester at a time and gates the collector enable while that requester is served.
- Bytes are delivered over a single valid/ready output tagged with the requester id.
- Enforces a repetition-count health test and a collection timeout. Either failure locks the block until software clears it.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- LEN_W, 8, width of per-request byte count.
- REP_LIMIT, 4, number of consecutive identical collector bytes that trips the health test (>=2).
- TIMEOUT_CYC, 4096, maximum cycles in COLLECT without byte_ready before a timeout fail.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level; must stay high until the last byte is accepted.
- req_len  in  N_REQ*LEN_W  per-requester byte count, slice i = [i*LEN_W +: LEN_W]; sampled only at grant.
- grant  out  N_REQ  one-hot; shows the requester currently served.
- collector_enable  out  1  drives the bit collector's enable input.
- byte_ready  in  1  one-cycle pulse from the bit collector.
- rand_byte  in  8  collector byte, valid when byte_ready is high.
- out_valid  out  1  delivered byte valid.
- out_data  out  8  delivered byte.
- out_id  out  $clog2(N_REQ)  index of the granted requester.
- out_last  out  1  marks the final byte of the request.
- out_ready  in  1  consumer accept.
- busy  out  1  high in any state other than IDLE.
- health_fail  out  1  sticky failure flag.
- fail_code  out  2  01 = repetition, 10 = timeout, 00 = none.
- clear_fail  in  1  leaves FAIL; ignored in other states.

Behaviour:
- Reset: state IDLE; all outputs 0; round-robin pointer favours requester 0; rep counter and timeout counter 0; previous-byte-valid flag 0.
- States: IDLE, COLLECT, DELIVER, FAIL. All outputs are registered.
- IDLE:
  - collector_enable = 0.
  - Eligible requesters are those with req[i] = 1 and req_len slice != 0. A request with length 0 is never granted.
  - If any requester is eligible, pick the first eligible index at or after the pointer (wrapping).
  - Next cycle: grant is that one-hot, remaining = req_len slice, pointer = winner+1 (mod N_REQ), state = COLLECT.
- COLLECT:
  - collector_enable = 1. The timeout counter increments every cycle and resets to 0 on entry.
  - On byte_ready, run the health test (below). If it passes: capture rand_byte, state = DELIVER.
  - In DELIVER the next cycle: out_valid = 1, out_id = winner index, out_last = (remaining == 1). collector_enable falls in the same cycle.
  - If the timeout counter reaches TIMEOUT_CYC-1 without byte_ready: state = FAIL, fail_code = 10.
- DELIVER:
  - out_data, out_id and out_last stay stable while out_valid = 1 and out_ready = 0.
  - On the out_valid & out_ready handshake: remaining decrements. If out_last was 1, go to IDLE and clear grant; otherwise go to COLLECT.
  - Back-to-back requests cost 1 idle cycle between grants.
- Abort:
  - If req[winner] falls in COLLECT or DELIVER, the next cycle is IDLE with grant = 0 and out_valid = 0.
  - Any captured or pending byte is discarded and never given to another requester.
  - Abort wins over a simultaneous byte_ready or handshake.
- Health test, applied to every collector byte accepted in COLLECT:
  - If the previous-byte-valid flag is set and rand_byte equals the previous byte, rep_count increments; otherwise rep_count = 1.
  - If rep_count reaches REP_LIMIT, the byte is discarded: state = FAIL, fail_code = 01.
  - The previous-byte-valid flag is set on the first byte. It clears on rst and clear_fail.
  - Only bytes from COLLECT are compared.
- byte_ready outside COLLECT is ignored: no capture and no health update.
- FAIL:
  - collector_enable = 0, out_valid = 0, grant = 0, health_fail = 1, fail_code held.
  - req is ignored.
  - When clear_fail = 1: next cycle IDLE, health_fail = 0, fail_code = 00, rep counter and previous-byte flag cleared. The pointer is unchanged.
- rst at any point returns to the reset state the next cycle, regardless of an in-flight byte.

Test Plan:
- Reset values: assert rst mid-COLLECT -> next cycle all outputs 0, busy = 0, collector_enable = 0.
- Single request: req[1] = 1, len = 3, bytes 0x11, 0x22, 0x33, out_ready = 1 -> three outputs with out_id = 1 and out_last only on 0x33; then grant = 0 and IDLE.
- Round-robin: req[0] and req[2] both held with len = 1 -> grant order 0, 2, 0, 2.
- Length-0 request: req[3] with len = 0 -> never granted.
- Backpressure and abort:
  - out_ready = 0 for 5 cycles -> out_data is stable and collector_enable = 0.
  - Dropping req[winner] in DELIVER -> out_valid = 0 the next cycle and the byte is not delivered.
- Health fail: REP_LIMIT = 4 with bytes 0xA5 x4 -> first three delivered, fourth not delivered; health_fail = 1, fail_code = 01. req is then ignored until a clear_fail pulse returns the block to IDLE.
- Timeout: TIMEOUT_CYC = 16, no byte_ready after grant -> FAIL with fail_code = 10 exactly 16 cycles after entering COLLECT.
